// File: rtl/mul_acc_seq_pkg.sv
// Shared widths, multiplier latency and FSM encoding for the mul_32 sequencing/accumulate stage.
package mul_acc_seq_pkg;
  localparam int PROD_W  = 64;
  localparam int GUARD   = 8;
  localparam int ACC_W   = PROD_W + GUARD;
  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mul_acc_seq_sat_add72.sv
// Signed ACC_W-bit add that clamps to the representable range on overflow.
module sat_add72
  import mul_acc_seq_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             clamped
);
  logic [ACC_W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign the result lost.
    clamped = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    if (!clamped)         sum = raw;
    else if (a[ACC_W-1])  sum = {1'b1, {(ACC_W-1){1'b0}}};
    else                  sum = {1'b0, {(ACC_W-1){1'b1}}};
  end
endmodule

// File: rtl/mul_acc_seq.sv
// Issues operand pairs into mul_32, tracks them through its latency and accumulates a dot product.
module mul_acc_seq
  import mul_acc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [PROD_W-1:0] sat_out,
  output logic              ovf,
  output logic              busy
);
  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               clamp_q, clamp_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [MUL_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic               fire, tap, add_clamped, in_range;
  logic [ACC_W-1:0]   add_sum;
  logic [CNT_W:0]     issue_inc, recv_inc;

  sat_add72 u_sat_add (
    .a       (acc_q),
    .b       ({{GUARD{prod[PROD_W-1]}}, prod}),
    .sum     (add_sum),
    .clamped (add_clamped)
  );

  assign fire = op_valid & (state_q == S_RUN);
  // Top tap lines up with the cycle prod holds the product of that fire.
  assign tap  = vld_pipe_q[MUL_LAT-1];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    clamp_d     = clamp_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    len_d       = len_q;
    vld_pipe_d  = (vld_pipe_q << 1) | MUL_LAT'(fire);
    issue_inc   = {1'b0, issue_cnt_q} + (CNT_W+1)'(1);
    recv_inc    = {1'b0, recv_cnt_q} + (CNT_W+1)'(1);
    case (state_q)
      S_IDLE: if (start) begin
        len_d       = len;
        acc_d       = '0;
        clamp_d     = 1'b0;
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        state_d     = (len != '0) ? S_RUN : S_DONE;
      end
      S_RUN, S_DRAIN: begin
        if (fire) begin
          issue_cnt_d = issue_inc[CNT_W-1:0];
          if (issue_inc == {1'b0, len_q}) state_d = S_DRAIN;
        end
        if (tap) begin
          acc_d      = add_sum;
          clamp_d    = clamp_q | add_clamped;
          recv_cnt_d = recv_inc[CNT_W-1:0];
          if (recv_inc == {1'b0, len_q}) state_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      clamp_q     <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      len_q       <= '0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      clamp_q     <= clamp_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      len_q       <= len_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  always_comb begin
    in_range = (&acc_q[ACC_W-1:PROD_W-1]) | ~(|acc_q[ACC_W-1:PROD_W-1]);
    if (in_range)            sat_out = acc_q[PROD_W-1:0];
    else if (acc_q[ACC_W-1]) sat_out = {1'b1, {(PROD_W-1){1'b0}}};
    else                     sat_out = {1'b0, {(PROD_W-1){1'b1}}};
  end

  assign acc_out   = acc_q;
  assign ovf       = clamp_q | ~in_range;
  assign op_ready  = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mul_acc_seq.sv
// Directed bench for mul_acc_seq with a 2-cycle behavioural stand-in for mul_32.
module tb_mul_acc_seq;
  import mul_acc_seq_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, op_valid, op_ready, out_valid, out_ready, ovf, busy;
  logic [CNT_W-1:0]  len;
  logic [PROD_W-1:0] prod, sat_out;
  logic [ACC_W-1:0]  acc_out;
  logic [31:0]       a_in, b_in, a_r, b_r;
  logic signed [31:0] pa [4];
  logic signed [31:0] pb [4];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Multiplier model: input register then output register.
  always @(posedge clk) begin
    a_r  <= a_in;
    b_r  <= b_in;
    prod <= {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
  end

  mul_acc_seq dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .sat_out(sat_out), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_cmd(input int n, input int gap, input int hold, input int poke,
                         output int lat, output logic [71:0] acc,
                         output logic signed [63:0] sat, output logic ov);
    int i, g, k;
    i = 0; g = 0; lat = 0;
    start = 1'b1; len = CNT_W'(n); op_valid = 1'b0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      start = (lat == poke);
      if (lat == poke) len = 16'd7;
      if (out_valid) break;
      if (i < n && g == 0 && op_ready) begin
        k = (i < 4) ? i : 3;
        op_valid = 1'b1; a_in = pa[k]; b_in = pb[k];
        i++; g = gap;
      end else begin
        op_valid = op_ready ? 1'b0 : 1'($urandom);
        a_in = $urandom; b_in = $urandom;
        if (g > 0) g--;
      end
    end
    op_valid = 1'b0; start = 1'b0;
    acc = acc_out; sat = sat_out; ov = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", acc_out, acc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int lat;
    logic [71:0] acc;
    logic signed [63:0] sat;
    logic ov;
    reset = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_sat", sat_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    pa = '{3, -5, 2, 2}; pb = '{4, 7, -6, -6};
    run_cmd(3, 0, 0, 0, lat, acc, sat, ov);
    chk("basic_lat", lat, 6);
    chk("basic_acc", acc, -35);
    chk("basic_sat", sat, -35);
    chk("basic_ovf", ov, 0);

    run_cmd(3, 2, 4, 0, lat, acc, sat, ov);
    chk("bubble_lat", lat, 10);
    chk("bubble_acc", acc, -35);

    pa = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
    pb = pa;
    run_cmd(2, 0, 0, 0, lat, acc, sat, ov);
    chk("ovf64_acc", acc, 72'h00_8000_0000_0000_0000);
    chk("ovf64_sat", sat, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf64_ovf", ov, 1);

    run_cmd(600, 0, 0, 0, lat, acc, sat, ov);
    chk("clamp_lat", lat, 603);
    chk("clamp_acc", acc, 72'h7F_FFFF_FFFF_FFFF_FFFF);
    chk("clamp_sat", sat, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("clamp_ovf", ov, 1);

    run_cmd(0, 0, 0, 0, lat, acc, sat, ov);
    chk("zero_lat", lat, 1);
    chk("zero_acc", acc, 0);
    chk("zero_ovf", ov, 0);

    pa = '{3, -5, 9, 9}; pb = '{4, 7, 9, 9};
    run_cmd(2, 0, 0, 2, lat, acc, sat, ov);
    chk("ignstart_lat", lat, 5);
    chk("ignstart_acc", acc, -23);

    // Abort a len=4 command while it drains.
    pa = '{100, 200, 300, 400}; pb = '{5, 6, 7, 8};
    start = 1'b1; len = 16'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0; op_valid = 1'b1; a_in = pa[k]; b_in = pb[k];
    end
    @(negedge clk);
    op_valid = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_op_ready", op_ready, 0);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_acc", acc_out, 0);
    chk("abort_sat", sat_out, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    pa = '{7, 7, 7, 7}; pb = '{8, 8, 8, 8};
    run_cmd(1, 0, 0, 0, lat, acc, sat, ov);
    chk("post_lat", lat, 4);
    chk("post_acc", acc, 56);
    chk("post_ovf", ov, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_acc_seq.md
Name: mul_acc_seq

Overview:
- Sequencing and accumulation stage placed directly downstream of the 32-bit Baugh-Wooley multiplier (mul_32).
- Gates operand pairs into the multiplier under a valid/ready handshake and tracks each pair through the multiplier's fixed 2-cycle latency.
- Accumulates the signed 64-bit products into a saturating wide accumulator and returns one dot-product result per command, with an output handshake.

Parameters:
- PROD_W, 64: product width; equals 2x the multiplier operand width.
- GUARD, 8: accumulator guard bits; ACC_W = PROD_W + GUARD = 72.
- MUL_LAT, 2: cycles from operand presentation to a valid product (input register plus output register).
- CNT_W, 16: width of the length and count fields.

Ports:
- clk, input, 1: single clock, shared with the multiplier.
- reset, input, 1: asynchronous, active-low. Shared with the multiplier.
- start, input, 1: begin a command; sampled in IDLE only.
- len, input, CNT_W: number of products in the command; sampled with start.
- op_valid, input, 1: the operand pair on the multiplier A_in/B_in is meaningful this cycle.
- op_ready, output, 1: the block accepts an operand pair this cycle.
- prod, input, PROD_W: multiplier output C, treated as signed.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- acc_out, output, ACC_W: full signed accumulator.
- sat_out, output, PROD_W: accumulator clamped to the signed 64-bit range.
- ovf, output, 1: acc_out does not fit in 64 signed bits, or the accumulator clamped.
- busy, output, 1: state is not IDLE.

Behaviour:
- Reset values (asynchronous, active-low): state=IDLE; accumulator, counters, valid pipe and sticky clamp flag all 0. Therefore op_ready=0, out_valid=0, acc_out=0, sat_out=0, ovf=0, busy=0. Reset in any state aborts the command and discards any in-flight products.
- Fire: fire = op_valid & op_ready. fire enters a MUL_LAT-deep shift register. The tap is high in cycle n+MUL_LAT for a fire in cycle n, which is exactly the cycle in which prod holds that pair's product.
- FSM state IDLE:
  - start with len != 0: go to RUN; clear accumulator, clamp flag, issue_cnt and recv_cnt.
  - start with len == 0: go to DONE with accumulator 0.
- FSM state RUN: op_ready=1. Each fire increments issue_cnt. The fire with issue_cnt+1 == len moves the state to DRAIN.
- FSM state DRAIN: op_ready=0. Wait for outstanding products.
- Accumulation (RUN and DRAIN): when the tap is high, acc <= sat72(acc + sign-extend(prod)) and recv_cnt increments. When recv_cnt+1 == len, go to DONE. This transition can occur directly from RUN only if MUL_LAT=0, which is not supported; MUL_LAT must be >= 1.
- sat72: on signed overflow of the 72-bit add, clamp to +(2^71-1) or -2^71 according to the operand signs, and set the sticky clamp flag.
- FSM state DONE: out_valid=1; outputs are held stable. out_ready returns the state to IDLE on the same edge. out_valid and out_ready may already be high together in the first DONE cycle.
- Latency: with back-to-back op_valid, out_valid rises len + MUL_LAT + 1 cycles after the cycle in which start is sampled. Gaps in op_valid add one cycle each.
- start is ignored outside IDLE. op_valid is ignored when op_ready=0; the garbage products the multiplier outputs for those cycles are never accumulated.
- sat_out is acc_out clamped to [-2^63, 2^63-1]. ovf = clamp flag OR (acc_out outside that range).
- acc_out, sat_out and ovf are combinational from the accumulator register; they are valid for the consumer only while out_valid=1.
- Counters are CNT_W wide; len = 2^CNT_W-1 is supported without wrap.

Decomposition:
- Shared package: MUL_LAT, PROD_W, the FSM state encoding, and the ACC_W derivation.
- Natural sub-module: sat_add72, a combinational signed 72-bit add with clamp that outputs {sum, clamped}.
- The multiplier is not instantiated inside this block. The top level wires op pairs to mul_32 and mul_32's C output to prod.

Test Plan:
- Basic dot product: start, len=3, pairs (3,4), (-5,7), (2,-6) back-to-back. Expect out_valid 6 cycles after start, acc_out=-35, sat_out=-35, ovf=0.
- Bubbles and backpressure: the same three pairs with op_valid low for 2 cycles between pairs, and out_ready held low for 4 cycles. Expect acc_out=-35, out_valid held and outputs stable until out_ready, then busy=0.
- 64-bit overflow: len=2, both pairs (-2^31, -2^31). Expect acc_out=2^63, sat_out=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Accumulator clamp: len=600, every pair (-2^31, -2^31). Expect acc_out=2^71-1, sat_out=2^63-1, ovf=1.
- Zero length and ignored start: len=0 gives out_valid the next cycle with acc_out=0. A start pulsed during RUN of a len=2 command has no effect on that command's result or length.
- Reset mid-operation: deassert reset during DRAIN of a len=4 command. All outputs go to 0 immediately. A following len=1 command with (7,8) yields 56 with no residue from the aborted command.
